dtw_dispatch_ctrl: RTL and testbench

Query dispatcher and result collector that shares N `dtw_core` lanes between one host input stream and one host output stream. It pops whole queries (1 ID word plus SQG_SIZE sample words) from the host input FIFO, starts an idle loaded lane, and streams the query into that lane's src FIFO. Independently, it drains each finished lane's 3-word result (qid, position, minval) from its sink FIFO into the host output FIFO. It sits between the AXI-stream FIFOs and the array of cores.

---
 rtl/dtw_dispatch_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_dtw_dispatch_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dtw_dispatch_ctrl
//
// Shares N_CORES dtw_core lanes between one host input stream and one host
// output stream.
//   * Dispatch side: pops whole queries (ID word + SQG_SIZE samples) from the
//     host input FIFO, starts an idle, loaded lane and streams the query into
//     that lane's src FIFO.
//   * Collect side: drains each finished lane's 3-word result (qid, position,
//     minval) from its sink FIFO into the host output FIFO.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   en                dispatch enable (collection always runs)
//   in_fifo_*         host input FIFO (FWFT): empty, head data, pop
//   core_busy         per-lane busy
//   core_load_done    per-lane reference loaded
//   core_rs           per-lane start (registered)
//   core_src_*        per-lane src FIFO: full, write strobe, shared data
//   core_sink_*       per-lane sink FIFO (FWFT): empty, packed data, pop
//   out_fifo_*        host output FIFO: full, write, data
//   dispatch_cnt      queries fully streamed (wraps)
//   result_cnt        results fully drained (wraps)
//   claimed           lane owns an outstanding query
// -----------------------------------------------------------------------------
module dtw_dispatch_ctrl #(
  parameter int N_CORES  = 4,
  parameter int SQG_SIZE = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_fifo_empty,
  input  logic [31:0]            in_fifo_data,
  output logic                   in_fifo_rden,
  input  logic [N_CORES-1:0]     core_busy,
  input  logic [N_CORES-1:0]     core_load_done,
  output logic [N_CORES-1:0]     core_rs,
  input  logic [N_CORES-1:0]     core_src_full,
  output logic [N_CORES-1:0]     core_src_wren,
  output logic [31:0]            core_src_data,
  input  logic [N_CORES-1:0]     core_sink_empty,
  input  logic [32*N_CORES-1:0]  core_sink_data,
  output logic [N_CORES-1:0]     core_sink_rden,
  input  logic                   out_fifo_full,
  output logic                   out_fifo_wren,
  output logic [31:0]            out_fifo_data,
  output logic [31:0]            dispatch_cnt,
  output logic [31:0]            result_cnt,
  output logic [N_CORES-1:0]     claimed
);

  localparam int SEL_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = $clog2(SQG_SIZE + 1);

  typedef enum logic [1:0] {D_IDLE, D_SELECT, D_START, D_STREAM} d_state_t;
  typedef enum logic       {C_SCAN, C_XFER} c_state_t;

  d_state_t           d_state;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   word_cnt;

  c_state_t           c_state;
  logic [SEL_W-1:0]   csel;
  logic [SEL_W-1:0]   crr_ptr;
  logic [1:0]         rcnt;

  // Round-robin pick: first set bit of req starting at ptr+1 (mod N_CORES).
  // Returns {found, index}.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_CORES-1:0] req,
                                             input logic [SEL_W-1:0]   ptr);
    logic             found;
    logic [SEL_W-1:0] pick;
    int               idx;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = (int'(ptr) + k) % N_CORES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
    return {found, pick};
  endfunction

  function automatic logic [N_CORES-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_CORES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [N_CORES-1:0] idle_vec;
  logic [N_CORES-1:0] ready_vec;
  logic [SEL_W:0]     d_pick;
  logic [SEL_W:0]     c_pick;
  logic               d_xfer;
  logic               d_last;
  logic               c_xfer;
  logic               c_last;
  logic [N_CORES-1:0] claim_set;
  logic [N_CORES-1:0] claim_clr;

  assign idle_vec  = core_load_done & ~core_busy & ~claimed;
  assign ready_vec = claimed & ~core_sink_empty;
  assign d_pick    = rr_pick(idle_vec, rr_ptr);
  assign c_pick    = rr_pick(ready_vec, crr_ptr);

  // Pass-through transfers are combinational from the FIFO flags so both
  // directions sustain one word per cycle.
  assign d_xfer = (d_state == D_STREAM) && !in_fifo_empty && !core_src_full[sel];
  assign d_last = d_xfer && (word_cnt == CNT_W'(SQG_SIZE));
  assign c_xfer = (c_state == C_XFER) && !core_sink_empty[csel] && !out_fifo_full;
  assign c_last = c_xfer && (rcnt == 2'd2);

  assign in_fifo_rden   = d_xfer;
  assign out_fifo_wren  = c_xfer;
  assign core_src_wren  = d_xfer ? onehot(sel)  : '0;
  assign core_sink_rden = c_xfer ? onehot(csel) : '0;
  // Data is gated by state so every output reads 0 while reset is held.
  assign core_src_data  = (d_state == D_STREAM) ? in_fifo_data : '0;
  assign out_fifo_data  = (c_state == C_XFER) ? core_sink_data[int'(csel)*32 +: 32] : '0;

  assign claim_set = d_last ? onehot(sel)  : '0;
  assign claim_clr = c_last ? onehot(csel) : '0;

  // A lane is only set when unclaimed and only cleared when claimed, so a
  // simultaneous set and clear always target different lanes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) claimed <= '0;
    else     claimed <= (claimed | claim_set) & ~claim_clr;
  end

  // Dispatch FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state      <= D_IDLE;
      sel          <= '0;
      rr_ptr       <= SEL_W'(N_CORES - 1);
      word_cnt     <= '0;
      core_rs      <= '0;
      dispatch_cnt <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (en && !in_fifo_empty) d_state <= D_SELECT;
        end
        D_SELECT: begin
          if (!en) begin
            d_state <= D_IDLE;
          end else if (d_pick[SEL_W]) begin
            sel     <= d_pick[SEL_W-1:0];
            core_rs <= onehot(d_pick[SEL_W-1:0]);
            d_state <= D_START;
          end
        end
        D_START: begin
          // The core flushes its src FIFO while idle, so wait for busy
          // before writing any word.
          if (core_busy[sel]) begin
            core_rs  <= '0;
            word_cnt <= '0;
            d_state  <= D_STREAM;
          end
        end
        D_STREAM: begin
          if (d_xfer) begin
            word_cnt <= word_cnt + 1'b1;
            if (d_last) begin
              rr_ptr       <= sel;
              dispatch_cnt <= dispatch_cnt + 32'd1;
              d_state      <= D_IDLE;
            end
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  // Collect FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state    <= C_SCAN;
      csel       <= '0;
      crr_ptr    <= SEL_W'(N_CORES - 1);
      rcnt       <= '0;
      result_cnt <= '0;
    end else begin
      case (c_state)
        C_SCAN: begin
          if (c_pick[SEL_W]) begin
            csel    <= c_pick[SEL_W-1:0];
            rcnt    <= '0;
            c_state <= C_XFER;
          end
        end
        C_XFER: begin
          // A lane's three result words are drained back-to-back; no other
          // lane is scanned until the third word has been popped.
          if (c_xfer) begin
            rcnt <= rcnt + 2'd1;
            if (c_last) begin
              crr_ptr    <= csel;
              result_cnt <= result_cnt + 32'd1;
              c_state    <= C_SCAN;
            end
          end
        end
        default: c_state <= C_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_dispatch_ctrl.sv
module tb_dtw_dispatch_ctrl;
  localparam int NC = 4;
  localparam int SQ = 250;
  localparam int QW = SQ + 1;

  logic              clk;
  logic              rst;
  logic              en;
  logic              in_fifo_empty;
  logic [31:0]       in_fifo_data;
  logic              in_fifo_rden;
  logic [NC-1:0]     core_busy;
  logic [NC-1:0]     core_load_done;
  logic [NC-1:0]     core_rs;
  logic [NC-1:0]     core_src_full;
  logic [NC-1:0]     core_src_wren;
  logic [31:0]       core_src_data;
  logic [NC-1:0]     core_sink_empty;
  logic [32*NC-1:0]  core_sink_data;
  logic [NC-1:0]     core_sink_rden;
  logic              out_fifo_full;
  logic              out_fifo_wren;
  logic [31:0]       out_fifo_data;
  logic [31:0]       dispatch_cnt;
  logic [31:0]       result_cnt;
  logic [NC-1:0]     claimed;

  int n_pass  = 0;
  int n_total = 0;

  dtw_dispatch_ctrl #(.N_CORES(NC), .SQG_SIZE(SQ)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_fifo_empty(in_fifo_empty), .in_fifo_data(in_fifo_data), .in_fifo_rden(in_fifo_rden),
    .core_busy(core_busy), .core_load_done(core_load_done), .core_rs(core_rs),
    .core_src_full(core_src_full), .core_src_wren(core_src_wren), .core_src_data(core_src_data),
    .core_sink_empty(core_sink_empty), .core_sink_data(core_sink_data), .core_sink_rden(core_sink_rden),
    .out_fifo_full(out_fifo_full), .out_fifo_wren(out_fifo_wren), .out_fifo_data(out_fifo_data),
    .dispatch_cnt(dispatch_cnt), .result_cnt(result_cnt), .claimed(claimed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Host input FIFO model
  logic [31:0] in_mem [0:2047];
  int          in_wr = 0;
  int          in_rd = 0;
  logic        in_hold;
  assign in_fifo_empty = (in_rd == in_wr) || in_hold;
  assign in_fifo_data  = in_mem[in_rd % 2048];
  always @(posedge clk or posedge rst) begin
    if (rst)               in_rd <= 0;
    else if (in_fifo_rden) in_rd <= in_rd + 1;
  end

  // Core model: busy one cycle after start, idle after the last query word;
  // every src write and every start pulse is logged.
  logic [31:0]   wr_data [0:2047];
  int            wr_lane [0:2047];
  int            wr_n = 0;
  int            oh_src_err = 0;
  int            cur_words [NC];
  int            rs_lane [0:63];
  int            rs_n = 0;
  logic [NC-1:0] rs_prev;
  logic          tog;
  logic          tog_en;
  assign core_src_full = {NC{tog}};
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_n      <= 0;
      rs_n      <= 0;
      rs_prev   <= '0;
      core_busy <= '0;
      tog       <= 1'b0;
      for (int i = 0; i < NC; i++) cur_words[i] <= 0;
    end else begin
      tog <= tog_en ? ~tog : 1'b0;
      if ($countones(core_src_wren) > 1) oh_src_err <= oh_src_err + 1;
      for (int i = 0; i < NC; i++)
        if (core_src_wren[i]) begin
          wr_lane[wr_n] <= i;
          wr_data[wr_n] <= core_src_data;
        end
      if (core_src_wren != '0) wr_n <= wr_n + 1;
      rs_prev <= core_rs;
      for (int i = 0; i < NC; i++)
        if (core_rs[i] && !rs_prev[i]) begin
          rs_lane[rs_n] <= i;
          rs_n          <= rs_n + 1;
        end
      for (int i = 0; i < NC; i++) begin
        if (core_rs[i]) begin
          core_busy[i] <= 1'b1;
          cur_words[i] <= 0;
        end else if (core_src_wren[i]) begin
          cur_words[i] <= cur_words[i] + 1;
          if (cur_words[i] == SQ) core_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Sink FIFO models
  logic [31:0] sink_mem [NC][8];
  int          sink_wr [NC];
  int          sink_rd [NC];
  always_comb begin
    core_sink_empty = '0;
    core_sink_data  = '0;
    for (int i = 0; i < NC; i++) begin
      core_sink_empty[i]       = (sink_rd[i] == sink_wr[i]);
      core_sink_data[32*i +: 32] = sink_mem[i][sink_rd[i] % 8];
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) sink_rd[i] <= 0;
    end else begin
      for (int i = 0; i < NC; i++)
        if (core_sink_rden[i]) sink_rd[i] <= sink_rd[i] + 1;
    end
  end

  // Host output FIFO log
  logic [31:0] out_log [0:63];
  int          out_n = 0;
  int          full_viol = 0;
  int          oh_sink_err = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      out_n <= 0;
    end else begin
      if ($countones(core_sink_rden) > 1) oh_sink_err <= oh_sink_err + 1;
      if (out_fifo_wren) begin
        out_log[out_n % 64] <= out_fifo_data;
        out_n               <= out_n + 1;
        if (out_fifo_full) full_viol <= full_viol + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] qword(input int id, input int k);
    return (k == 0) ? 32'(id) : {16'(id), 16'(k)};
  endfunction

  task automatic push_query(input int id);
    for (int k = 0; k < QW; k++) begin
      in_mem[in_wr % 2048] = qword(id, k);
      in_wr = in_wr + 1;
    end
  endtask

  task automatic push_result(input int lane, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c);
    sink_mem[lane][sink_wr[lane] % 8]       = a;
    sink_mem[lane][(sink_wr[lane] + 1) % 8] = b;
    sink_mem[lane][(sink_wr[lane] + 2) % 8] = c;
    sink_wr[lane] = sink_wr[lane] + 3;
  endtask

  task automatic check_stream(input string tag, input int start, input int lane, input int id);
    int bad;
    bad = 0;
    for (int k = 0; k < QW; k++)
      if (wr_lane[start + k] != lane || wr_data[start + k] !== qword(id, k)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic wait_dispatch(input string tag, input int n);
    int t;
    t = 0;
    while (dispatch_cnt != 32'(n) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, dispatch_cnt, n);
  endtask

  task automatic wait_result(input string tag, input int n);
    int t;
    t = 0;
    while (result_cnt != 32'(n) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, result_cnt, n);
  endtask

  task automatic wait_wrn(input string tag, input int n);
    int t;
    t = 0;
    while (wr_n < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, wr_n >= n, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    en            = 1'b0;
    in_hold       = 1'b0;
    tog_en        = 1'b0;
    out_fifo_full = 1'b0;
    in_wr         = 0;
    for (int i = 0; i < NC; i++) sink_wr[i] = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    in_hold        = 1'b0;
    tog_en         = 1'b0;
    out_fifo_full  = 1'b0;
    core_load_done = '0;
    for (int i = 0; i < NC; i++) sink_wr[i] = 0;
    tick(1);

    // Reset state
    check("rst_rden",      in_fifo_rden,   0);
    check("rst_rs",        core_rs,        0);
    check("rst_src_wren",  core_src_wren,  0);
    check("rst_sink_rden", core_sink_rden, 0);
    check("rst_out_wren",  out_fifo_wren,  0);
    check("rst_dcnt",      dispatch_cnt,   0);
    check("rst_rcnt",      result_cnt,     0);
    check("rst_claimed",   claimed,        0);
    rst = 1'b0;
    tick(1);

    // Single query to lane 0, then a result drain under output backpressure
    core_load_done = 4'b0001;
    en = 1'b1;
    push_query(32'h55);
    tick(3);
    check("lat_rs",       core_rs,       4'b0001);
    check("lat_no_wr",    core_src_wren, 0);
    tick(1);
    check("lat_first_wr", core_src_wren, 4'b0001);
    wait_dispatch("q1_done", 1);
    check("q1_rs_n",    rs_n,       1);
    check("q1_rs_lane", rs_lane[0], 0);
    check("q1_wr_n",    wr_n,       QW);
    check_stream("q1_data", 0, 0, 32'h55);
    check("q1_claimed", claimed, 4'b0001);
    out_fifo_full = 1'b1;
    push_result(0, 32'h55, 32'h1234, 32'h7);
    tick(20);
    check("stall_out_n",   out_n,      0);
    check("stall_rcnt",    result_cnt, 0);
    check("stall_claimed", claimed,    4'b0001);
    out_fifo_full = 1'b0;
    wait_result("r1_done", 1);
    check("r1_out_n",   out_n,      3);
    check("r1_word0",   out_log[0], 32'h55);
    check("r1_word1",   out_log[1], 32'h1234);
    check("r1_word2",   out_log[2], 32'h7);
    check("r1_claimed", claimed,    0);

    // Round-robin dispatch with results held
    do_reset();
    core_load_done = 4'b1111;
    en = 1'b1;
    for (int q = 1; q <= 5; q++) push_query(q);
    wait_dispatch("rr4_done", 4);
    tick(300);
    check("rr_held_dcnt", dispatch_cnt, 4);
    check("rr_held_rden", in_fifo_rden, 0);
    check("rr_rs_n",      rs_n,         4);
    for (int q = 0; q < 4; q++) begin
      check("rr_lane", rs_lane[q], q);
      check_stream("rr_data", q * QW, q, q + 1);
    end
    check("rr_claimed", claimed, 4'b1111);
    push_result(0, 32'h1, 32'hA0, 32'hA1);
    wait_result("rr_r1", 1);
    wait_dispatch("rr5_done", 5);
    check("rr5_lane", rs_lane[4], 0);
    check_stream("rr5_data", 4 * QW, 0, 5);
    check("rr_out0",   out_log[0], 32'h1);
    check("rr_claimed5", claimed, 4'b1111);

    // Load gating, then src FIFO toggling and input starvation mid-stream
    do_reset();
    core_load_done = 4'b0010;
    en = 1'b1;
    push_query(32'h31);
    wait_dispatch("lg1_done", 1);
    check_stream("lg1_data", 0, 1, 32'h31);
    push_result(1, 32'h31, 32'h1, 32'h2);
    wait_result("lg_r1", 1);
    push_query(32'h32);
    wait_wrn("bp_mid", QW + 20);
    tog_en = 1'b1;
    wait_wrn("bp_hold_at", QW + 100);
    in_hold = 1'b1;
    tick(10);
    check("bp_hold_no_wr", wr_n, QW + 100);
    in_hold = 1'b0;
    wait_dispatch("bp_done", 2);
    tog_en = 1'b0;
    check("bp_wr_n", wr_n, 2 * QW);
    check_stream("bp_data", QW, 1, 32'h32);
    check("lg_rs_n",     rs_n,       2);
    check("lg_rs_lane0", rs_lane[0], 1);
    check("lg_rs_lane1", rs_lane[1], 1);

    // Two lanes present results together while lane 3 streams
    do_reset();
    core_load_done = 4'b1111;
    en = 1'b1;
    push_query(32'h41);
    push_query(32'h42);
    push_query(32'h43);
    wait_dispatch("cc3_done", 3);
    push_query(32'h44);
    wait_wrn("cc_mid", 3 * QW + 50);
    push_result(1, 32'hB, 32'h100, 32'h1);
    push_result(2, 32'hC, 32'h200, 32'h2);
    wait_result("cc_r2", 2);
    check("cc_streaming", in_fifo_rden, 1);
    check("cc_out_n", out_n, 6);
    check("cc_o0", out_log[0], 32'hB);
    check("cc_o1", out_log[1], 32'h100);
    check("cc_o2", out_log[2], 32'h1);
    check("cc_o3", out_log[3], 32'hC);
    check("cc_o4", out_log[4], 32'h200);
    check("cc_o5", out_log[5], 32'h2);
    wait_dispatch("cc4_done", 4);
    check("cc4_lane", rs_lane[3], 3);
    check_stream("cc4_data", 3 * QW, 3, 32'h44);
    check("cc_claimed", claimed, 4'b1001);

    // Asynchronous reset in the middle of a query
    do_reset();
    core_load_done = 4'b0001;
    en = 1'b1;
    push_query(32'h66);
    wait_wrn("ar_mid", 100);
    check("ar_pre_rden", in_fifo_rden, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rden",      in_fifo_rden,  0);
    check("ar_src_wren",  core_src_wren, 0);
    check("ar_src_data",  core_src_data, 0);
    check("ar_rs",        core_rs,       0);
    check("ar_dcnt",      dispatch_cnt,  0);
    check("ar_claimed",   claimed,       0);
    check("ar_out_wren",  out_fifo_wren, 0);
    en    = 1'b0;
    in_wr = 0;
    for (int i = 0; i < NC; i++) sink_wr[i] = 0;
    tick(2);
    rst = 1'b0;
    tick(1);
    en = 1'b1;
    push_query(32'h67);
    wait_dispatch("ar_q_done", 1);
    check("ar_wr_n", wr_n, QW);
    check_stream("ar_data", 0, 0, 32'h67);
    check("ar_claimed_after", claimed, 4'b0001);

    // Global invariants collected over the whole run
    check("src_onehot",  oh_src_err,  0);
    check("sink_onehot", oh_sink_err, 0);
    check("out_full_wr", full_viol,   0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
